// File: rtl/mac_keyboard.sv
// ---------------------------------------------------------------------------
// mac_keyboard
//
// Emulated M0110 Macintosh keyboard. Sits between the PS/2 receiver and the
// VIA shift-register model: PS/2 set-2 events are translated into Mac
// transition bytes and queued in a small FIFO. Host command bytes
// (Inquiry / Instant / Model / Test) are answered with one response byte.
//
// Ports
//   clk_cpu     in   1   system clock
//   reset       in   1   synchronous, active-high
//   ps2_key     in   11  [10] toggle strobe, [9] pressed, [8] extended,
//                        [7:0] set-2 scancode
//   cmd_valid   in   1   one-cycle pulse: host command byte available
//   cmd_data    in   8   host command byte
//   rsp_valid   out  1   one-cycle pulse: response byte ready
//   rsp_data    out  8   response byte, held until the next rsp_valid
//   busy        out  1   high whenever the responder is not idle
//   fifo_count  out  4   number of queued transition bytes
//   overflow    out  1   sticky: an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module mac_keyboard #(
    parameter int         c_mhz        = 25000000,
    parameter int         c_inquiry_ms = 250,
    parameter int         c_fifo_log2  = 3,
    parameter logic [7:0] c_model      = 8'h09
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic [3:0]  fifo_count,
    output logic        overflow
);

    localparam int c_depth   = 1 << c_fifo_log2;
    localparam int c_cw      = c_fifo_log2 + 1;
    localparam int c_timeout = (c_mhz / 1000) * c_inquiry_ms - 1;
    localparam int c_tw      = (c_timeout > 0) ? $clog2(c_timeout + 1) : 1;

    localparam logic [7:0] c_cmd_inquiry = 8'h10;
    localparam logic [7:0] c_cmd_instant = 8'h14;
    localparam logic [7:0] c_cmd_model   = 8'h16;
    localparam logic [7:0] c_cmd_test    = 8'h36;
    localparam logic [7:0] c_null        = 8'h7B;
    localparam logic [7:0] c_ack         = 8'h7D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INQUIRE,
        S_RESPOND
    } state_t;

    // Set-2 {ext, code} to Mac raw key number. Bit 6 of the result flags a
    // mapped key; unmapped keys are simply not queued.
    function automatic logic [6:0] f_translate(input logic [8:0] key);
        logic [6:0] res;
        res = 7'h00;
        case (key)
            9'h01C: res = {1'b1, 6'h00};   // A
            9'h01B: res = {1'b1, 6'h01};   // S
            9'h023: res = {1'b1, 6'h02};   // D
            9'h02B: res = {1'b1, 6'h03};   // F
            9'h033: res = {1'b1, 6'h04};   // H
            9'h034: res = {1'b1, 6'h05};   // G
            9'h01A: res = {1'b1, 6'h06};   // Z
            9'h022: res = {1'b1, 6'h07};   // X
            9'h021: res = {1'b1, 6'h08};   // C
            9'h02A: res = {1'b1, 6'h09};   // V
            9'h032: res = {1'b1, 6'h0B};   // B
            9'h015: res = {1'b1, 6'h0C};   // Q
            9'h01D: res = {1'b1, 6'h0D};   // W
            9'h024: res = {1'b1, 6'h0E};   // E
            9'h02D: res = {1'b1, 6'h0F};   // R
            9'h035: res = {1'b1, 6'h10};   // Y
            9'h02C: res = {1'b1, 6'h11};   // T
            9'h016: res = {1'b1, 6'h12};   // 1
            9'h01E: res = {1'b1, 6'h13};   // 2
            9'h026: res = {1'b1, 6'h14};   // 3
            9'h025: res = {1'b1, 6'h15};   // 4
            9'h036: res = {1'b1, 6'h16};   // 6
            9'h02E: res = {1'b1, 6'h17};   // 5
            9'h055: res = {1'b1, 6'h18};   // =
            9'h046: res = {1'b1, 6'h19};   // 9
            9'h03D: res = {1'b1, 6'h1A};   // 7
            9'h04E: res = {1'b1, 6'h1B};   // -
            9'h03E: res = {1'b1, 6'h1C};   // 8
            9'h045: res = {1'b1, 6'h1D};   // 0
            9'h05B: res = {1'b1, 6'h1E};   // ]
            9'h044: res = {1'b1, 6'h1F};   // O
            9'h03C: res = {1'b1, 6'h20};   // U
            9'h054: res = {1'b1, 6'h21};   // [
            9'h043: res = {1'b1, 6'h22};   // I
            9'h04D: res = {1'b1, 6'h23};   // P
            9'h05A: res = {1'b1, 6'h24};   // Return
            9'h04B: res = {1'b1, 6'h25};   // L
            9'h03B: res = {1'b1, 6'h26};   // J
            9'h052: res = {1'b1, 6'h27};   // '
            9'h042: res = {1'b1, 6'h28};   // K
            9'h04C: res = {1'b1, 6'h29};   // ;
            9'h05D: res = {1'b1, 6'h2A};   // backslash
            9'h041: res = {1'b1, 6'h2B};   // ,
            9'h04A: res = {1'b1, 6'h2C};   // /
            9'h031: res = {1'b1, 6'h2D};   // N
            9'h03A: res = {1'b1, 6'h2E};   // M
            9'h049: res = {1'b1, 6'h2F};   // .
            9'h00D: res = {1'b1, 6'h30};   // Tab
            9'h029: res = {1'b1, 6'h31};   // Space
            9'h00E: res = {1'b1, 6'h32};   // `
            9'h066: res = {1'b1, 6'h33};   // Backspace
            9'h014: res = {1'b1, 6'h37};   // left Ctrl -> Command
            9'h11F: res = {1'b1, 6'h37};   // left GUI  -> Command
            9'h127: res = {1'b1, 6'h37};   // right GUI -> Command
            9'h012: res = {1'b1, 6'h38};   // left Shift
            9'h059: res = {1'b1, 6'h38};   // right Shift
            9'h058: res = {1'b1, 6'h39};   // Caps Lock
            9'h011: res = {1'b1, 6'h3A};   // left Alt  -> Option
            9'h111: res = {1'b1, 6'h3A};   // right Alt -> Option
            default: res = 7'h00;
        endcase
        return res;
    endfunction

    state_t                   r_state;
    logic                     r_rsp_valid;
    logic [7:0]               r_rsp_data;
    logic [c_tw-1:0]          r_timer;
    logic                     r_toggle;
    logic [7:0]               r_mem [c_depth];
    logic [c_fifo_log2-1:0]   r_wr_ptr;
    logic [c_fifo_log2-1:0]   r_rd_ptr;
    logic [c_cw-1:0]          r_count;
    logic                     r_overflow;

    logic [6:0]               w_xlat;
    logic                     w_push;
    logic                     w_push_ok;
    logic                     w_pop;
    logic                     w_flush;
    logic                     w_full;
    logic                     w_nonempty;
    logic [7:0]               w_event_byte;
    logic [7:0]               w_head;

    assign w_xlat       = f_translate(ps2_key[8:0]);
    // A change of the strobe bit relative to the registered copy is one event.
    assign w_push       = (ps2_key[10] != r_toggle) && w_xlat[6];
    assign w_event_byte = {~ps2_key[9], w_xlat[5:0], 1'b1};
    assign w_full       = (r_count == c_cw'(c_depth));
    assign w_nonempty   = (r_count != '0);
    assign w_head       = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign w_push_ok    = w_push && (!w_full || w_pop);

    always_comb begin
        w_pop   = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_data == c_cmd_inquiry || cmd_data == c_cmd_instant) && w_nonempty)
                        w_pop = 1'b1;
                    if (cmd_data == c_cmd_model)
                        w_flush = 1'b1;
                end
            end
            S_INQUIRE: begin
                if (w_nonempty)
                    w_pop = 1'b1;
            end
            default: begin
                w_pop   = 1'b0;
                w_flush = 1'b0;
            end
        endcase
    end

    // Strobe tracker follows the input even in reset so release is quiet.
    always_ff @(posedge clk_cpu) begin
        r_toggle <= ps2_key[10];
    end

    always_ff @(posedge clk_cpu) begin
        if (!reset && !w_flush && w_push_ok)
            r_mem[r_wr_ptr] <= w_event_byte;
    end

    always_ff @(posedge clk_cpu) begin
        if (reset || w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_push_ok)
                r_overflow <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Responder FSM. rsp_valid is raised on the edge that enters RESPOND,
    // so it is high for exactly the single RESPOND cycle.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_timer     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_data)
                            c_cmd_inquiry: begin
                                if (w_nonempty) begin
                                    r_rsp_data  <= w_head;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= S_RESPOND;
                                end else begin
                                    r_timer <= '0;
                                    r_state <= S_INQUIRE;
                                end
                            end
                            c_cmd_instant: begin
                                r_rsp_data  <= w_nonempty ? w_head : c_null;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RESPOND;
                            end
                            c_cmd_model: begin
                                r_rsp_data  <= c_model;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RESPOND;
                            end
                            c_cmd_test: begin
                                r_rsp_data  <= c_ack;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RESPOND;
                            end
                            default: begin
                                r_rsp_data  <= c_null;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RESPOND;
                            end
                        endcase
                    end
                end
                S_INQUIRE: begin
                    // A queued event takes priority over a coincident timeout.
                    if (w_nonempty) begin
                        r_rsp_data  <= w_head;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESPOND;
                    end else if (r_timer == c_tw'(c_timeout)) begin
                        r_rsp_data  <= c_null;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESPOND;
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end
                S_RESPOND: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = 4'(r_count);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_mac_keyboard.sv
module tb_mac_keyboard;

    logic        clk_cpu;
    logic        reset;
    logic [10:0] ps2_key;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int tests;
    int fails;
    logic tog;
    logic [7:0] exp_q[$];

    mac_keyboard #(
        .c_mhz        (1000000),
        .c_inquiry_ms (1),
        .c_fifo_log2  (3),
        .c_model      (8'h09)
    ) dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // Present one PS/2 event (strobe flip) at a falling edge.
    task automatic press(input logic [7:0] code, input logic pressed, input logic ext);
        @(negedge clk_cpu);
        tog = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic drive_cmd(input logic [7:0] c);
        @(negedge clk_cpu);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge clk_cpu);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid, sampling on falling edges.
    task automatic wait_rsp(input int budget, output logic seen, output logic [7:0] got,
                            output int waited);
        seen = 1'b0; got = 8'h00; waited = 0;
        while (!seen && waited < budget) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                got  = rsp_data;
            end else begin
                @(negedge clk_cpu);
                waited++;
            end
        end
    endtask

    // Scoreboard round trip: push expectation, issue command, collect reply.
    task automatic issue(input logic [7:0] c, input logic [7:0] e, output logic seen,
                         output logic [7:0] got, output int waited, output logic [7:0] exp);
        exp_q.push_back(e);
        drive_cmd(c);
        wait_rsp(20, seen, got, waited);
        exp = exp_q.pop_front();
    endtask

    task automatic pulse_reset();
        @(negedge clk_cpu);
        reset = 1'b1;
        repeat (2) @(negedge clk_cpu);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_cpu);
        tog = ~tog;
        ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
        repeat (2) @(negedge clk_cpu);
        reset = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b d=%h busy=%b exp v=0 d=00 busy=0", rsp_valid, rsp_data, busy);
        end
        tests++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_fifo got cnt=%0d ovf=%b exp cnt=0 ovf=0", fifo_count, overflow);
        end
        repeat (3) @(negedge clk_cpu);
        tests++;
        if (fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_no_spurious got cnt=%0d exp 0", fifo_count);
        end
    endtask

    task automatic test_instant();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited;
        press(8'h1C, 1'b1, 1'b0);
        issue(8'h14, 8'h01, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp || waited != 0) begin
            fails++;
            $display("FAIL instant_press got seen=%b d=%h lat=%0d exp d=%h lat=0", seen, got, waited, exp);
        end
        @(negedge clk_cpu);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL instant_one_cycle got v=%b busy=%b exp 0 0", rsp_valid, busy);
        end
        press(8'h1C, 1'b0, 1'b0);
        issue(8'h14, 8'h81, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp || waited != 0) begin
            fails++;
            $display("FAIL instant_release got seen=%b d=%h lat=%0d exp d=%h", seen, got, waited, exp);
        end
        issue(8'h14, 8'h7B, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp) begin
            fails++;
            $display("FAIL instant_empty got seen=%b d=%h exp %h", seen, got, exp);
        end
    endtask

    task automatic test_inquiry_timeout();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited; int busy_low; int extra;
        exp_q.push_back(8'h7B);
        drive_cmd(8'h10);
        seen = 1'b0; got = 8'h00; waited = 0; busy_low = 0;
        while (!seen && waited < 2000) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                got  = rsp_data;
            end else begin
                if (busy !== 1'b1) busy_low++;
                @(negedge clk_cpu);
                waited++;
                if (waited == 500) begin
                    cmd_valid = 1'b1;
                    cmd_data  = 8'h36;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        exp = exp_q.pop_front();
        tests++;
        if (!seen || got !== exp) begin
            fail_line("inquiry_timeout_data", seen, got, exp);
        end
        tests++;
        if (waited != 1000) begin
            fails++;
            $display("FAIL inquiry_timeout_latency got %0d exp 1000", waited);
        end
        tests++;
        if (busy_low != 0) begin
            fails++;
            $display("FAIL inquiry_busy got %0d idle cycles exp 0", busy_low);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk_cpu);
            if (rsp_valid === 1'b1) extra++;
        end
        tests++;
        if (extra != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL inquiry_ignored_cmd got extra=%0d busy=%b exp 0 0", extra, busy);
        end
    endtask

    task automatic fail_line(input string name, input logic seen, input logic [7:0] got,
                             input logic [7:0] exp);
        fails++;
        $display("FAIL %s got seen=%b d=%h exp d=%h", name, seen, got, exp);
    endtask

    task automatic test_inquiry_event();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited;
        drive_cmd(8'h10);
        repeat (199) @(negedge clk_cpu);
        tests++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL inquiry_wait got busy=%b v=%b exp 1 0", busy, rsp_valid);
        end
        exp_q.push_back(8'h63);
        press(8'h29, 1'b1, 1'b0);
        wait_rsp(20, seen, got, waited);
        exp = exp_q.pop_front();
        tests++;
        if (!seen || got !== exp || waited != 2) begin
            fails++;
            $display("FAIL inquiry_event got seen=%b d=%h lat=%0d exp d=%h lat=2", seen, got, waited, exp);
        end
        @(negedge clk_cpu);
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL inquiry_event_done got busy=%b v=%b cnt=%0d exp 0 0 0", busy, rsp_valid, fifo_count);
        end
    endtask

    task automatic test_overflow();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited;
        repeat (9) press(8'h1C, 1'b1, 1'b0);
        repeat (2) @(negedge clk_cpu);
        tests++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_full got cnt=%0d ovf=%b exp 8 1", fifo_count, overflow);
        end
        issue(8'h16, 8'h09, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp) fail_line("model_reply", seen, got, exp);
        tests++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL model_flush got cnt=%0d ovf=%b exp 0 0", fifo_count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited; int bad;
        repeat (8) press(8'h1C, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h01);
        exp_q.push_back(8'h63);
        // Push into a full FIFO in the same cycle as a pop.
        @(negedge clk_cpu);
        tog = ~tog;
        ps2_key = {tog, 1'b1, 1'b0, 8'h29};
        cmd_valid = 1'b1;
        cmd_data  = 8'h14;
        @(negedge clk_cpu);
        cmd_valid = 1'b0;
        wait_rsp(20, seen, got, waited);
        tests++;
        if (!seen || got !== 8'h01) fail_line("full_pop_reply", seen, got, 8'h01);
        tests++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_push got cnt=%0d ovf=%b exp 8 0", fifo_count, overflow);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cmd(8'h14);
            wait_rsp(20, seen, got, waited);
            exp = exp_q.pop_front();
            if (!seen || got !== exp) begin
                bad++;
                $display("FAIL drain_%0d got seen=%b d=%h exp %h", i, seen, got, exp);
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic test_misc_cmds();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited;
        issue(8'h36, 8'h7D, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp || waited != 0) fail_line("test_ack", seen, got, exp);
        issue(8'h55, 8'h7B, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp) fail_line("unknown_cmd", seen, got, exp);
        press(8'h07, 1'b1, 1'b0);
        repeat (3) @(negedge clk_cpu);
        tests++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL unmapped_drop got cnt=%0d ovf=%b exp 0 0", fifo_count, overflow);
        end
        press(8'h1F, 1'b1, 1'b1);
        issue(8'h14, 8'h6F, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp) fail_line("extended_gui", seen, got, exp);
    endtask

    task automatic test_reset_mid_inquire();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited; int pulses;
        drive_cmd(8'h10);
        repeat (100) @(negedge clk_cpu);
        pulse_reset();
        pulses = 0;
        repeat (1100) begin
            @(negedge clk_cpu);
            if (rsp_valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0 || busy !== 1'b0 || fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid_inquire got pulses=%0d busy=%b cnt=%0d exp 0 0 0", pulses, busy, fifo_count);
        end
        issue(8'h14, 8'h7B, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp) fail_line("after_reset_instant", seen, got, exp);
    endtask

    task automatic test_reset_flush();
        logic seen; logic [7:0] got; logic [7:0] exp; int waited;
        repeat (3) press(8'h66, 1'b1, 1'b0);
        repeat (2) @(negedge clk_cpu);
        tests++;
        if (fifo_count !== 4'd3) begin
            fails++;
            $display("FAIL reset_flush_fill got cnt=%0d exp 3", fifo_count);
        end
        pulse_reset();
        @(negedge clk_cpu);
        tests++;
        if (fifo_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_flush got cnt=%0d exp 0", fifo_count);
        end
        issue(8'h14, 8'h7B, seen, got, waited, exp);
        tests++;
        if (!seen || got !== exp) fail_line("reset_flush_instant", seen, got, exp);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        tog = 1'b0;
        reset = 1'b1;
        ps2_key = 11'h000;
        cmd_valid = 1'b0;
        cmd_data = 8'h00;
        repeat (3) @(negedge clk_cpu);
        test_reset();
        test_instant();
        test_inquiry_timeout();
        test_inquiry_event();
        test_overflow();
        test_back_to_back();
        test_misc_cmds();
        test_reset_mid_inquire();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
